gpio_debounce: RTL and testbench

GPIO_DEBOUNCE -- requirements
Module: gpio_debounce

---
 rtl/gpio_debounce.sv | 162 ++++++++++++++++
 tb/tb_gpio_debounce.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_debounce.sv
// Four-channel push-button debouncer with press/release strobes and auto-repeat.
// Each channel is synchronized, normalized to active-high, then qualified by a
// small FSM that requires DEBOUNCE_CYCLES consecutive equal samples before it
// accepts a level change.
//
// state        | meaning
// -------------+----------------------------------------------------------
// S_IDLE       | button released and accepted as released
// S_DB_PRESS   | input went active, counting stable pressed samples
// S_HELD       | press accepted, gpio_export high, auto-repeat running
// S_DB_RELEASE | input went inactive, counting stable released samples
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [3:0] btn_raw,
    output logic [3:0] gpio_export,
    output logic [3:0] press_pulse,
    output logic [3:0] release_pulse,
    output logic [3:0] repeat_pulse
);

    localparam int MAX_DB_RD = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_ALL   = (MAX_DB_RD > REPEAT_PERIOD) ? MAX_DB_RD : REPEAT_PERIOD;
    // One extra code point so a power-of-two parameter value still fits.
    localparam int CW        = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    // Terminal values are one below the interval because the counter restarts at 0.
    localparam logic [CW-1:0] RD_TERM = CW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [CW-1:0] RP_TERM = CW'(REPEAT_PERIOD - 1);
    localparam bit            REPEAT_EN = (REPEAT_DELAY != 0);
    // Raw pin level of a released button; the synchronizer resets to it.
    localparam logic          RAW_IDLE  = ACTIVE_LOW;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_DB_PRESS   = 2'd1,
        S_HELD       = 2'd2,
        S_DB_RELEASE = 2'd3
    } state_t;

    for (genvar ch = 0; ch < 4; ch++) begin : g_ch
        logic          sync1, sync2, level;
        state_t        state, state_nx;
        logic [CW-1:0] db_cnt, db_cnt_nx, db_inc;
        logic [CW-1:0] rep_cnt;
        logic          rep_first;
        logic          press_nx, release_nx;
        logic          press_q, release_q, repeat_q, gpio_q;

        // Two-flop synchronizer for the asynchronous pin.
        always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) begin
                sync1 <= RAW_IDLE;
                sync2 <= RAW_IDLE;
            end else begin
                sync1 <= btn_raw[ch];
                sync2 <= sync1;
            end
        end

        assign level  = sync2 ^ ACTIVE_LOW;
        assign db_inc = db_cnt + CW'(1);

        // Next-state logic: a level change is accepted once the counter reaches DB_LAST.
        always_comb begin
            state_nx   = state;
            db_cnt_nx  = db_cnt;
            press_nx   = 1'b0;
            release_nx = 1'b0;
            case (state)
                S_IDLE: begin
                    if (level) begin
                        state_nx  = S_DB_PRESS;
                        db_cnt_nx = '0;
                    end
                end
                S_DB_PRESS: begin
                    if (!level) begin
                        state_nx = S_IDLE;
                    end else begin
                        db_cnt_nx = db_inc;
                        if (db_inc == DB_LAST) begin
                            state_nx = S_HELD;
                            press_nx = 1'b1;
                        end
                    end
                end
                S_HELD: begin
                    if (!level) begin
                        state_nx  = S_DB_RELEASE;
                        db_cnt_nx = '0;
                    end
                end
                S_DB_RELEASE: begin
                    if (level) begin
                        state_nx = S_HELD;
                    end else begin
                        db_cnt_nx = db_inc;
                        if (db_inc == DB_LAST) begin
                            state_nx   = S_IDLE;
                            release_nx = 1'b1;
                        end
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end

        // State, debounce counter and registered press/release/level outputs.
        always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) begin
                state     <= S_IDLE;
                db_cnt    <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                gpio_q    <= 1'b0;
            end else begin
                state     <= state_nx;
                db_cnt    <= db_cnt_nx;
                press_q   <= press_nx;
                release_q <= release_nx;
                gpio_q    <= (state_nx == S_HELD) || (state_nx == S_DB_RELEASE);
            end
        end

        // Auto-repeat: counter keeps its cadence through a release bounce, but a
        // strobe is only emitted when the channel is HELD on both sides of the edge.
        always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) begin
                rep_cnt   <= '0;
                rep_first <= 1'b1;
                repeat_q  <= 1'b0;
            end else begin
                repeat_q <= 1'b0;
                if (press_nx) begin
                    rep_cnt   <= '0;
                    rep_first <= 1'b1;
                end else if (REPEAT_EN && (state == S_HELD || state == S_DB_RELEASE)) begin
                    if (rep_cnt == (rep_first ? RD_TERM : RP_TERM)) begin
                        rep_cnt   <= '0;
                        rep_first <= 1'b0;
                        repeat_q  <= (state == S_HELD) && (state_nx == S_HELD);
                    end else begin
                        rep_cnt <= rep_cnt + CW'(1);
                    end
                end
            end
        end

        assign gpio_export[ch]   = gpio_q;
        assign press_pulse[ch]   = press_q;
        assign release_pulse[ch] = release_q;
        assign repeat_pulse[ch]  = repeat_q;
    end

endmodule

// File: tb/tb_gpio_debounce.sv
// Self-checking bench for gpio_debounce. A run-length reference model tracks,
// per channel, the accepted level, how many consecutive opposite samples have
// been seen, and the time since the last accepted press; repeat strobes are
// predicted arithmetically from that time.
module tb_gpio_debounce;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic       clk_clk = 1'b0;
    logic       reset_reset = 1'b1;
    logic [3:0] btn_raw = 4'hF;
    logic [3:0] gpio_export, press_pulse, release_pulse, repeat_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_debounce #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .btn_raw      (btn_raw),
        .gpio_export  (gpio_export),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse)
    );

    always #5 clk_clk = ~clk_clk;

    // Reference model state
    logic [3:0] raw_dly [2];
    bit         m_level [4];
    int         m_run   [4];
    int         m_since [4];
    logic [3:0] e_gpio, e_press, e_rel, e_rep;

    function automatic logic [15:0] outs();
        return {gpio_export, press_pulse, release_pulse, repeat_pulse};
    endfunction

    function automatic logic [15:0] exps();
        return {e_gpio, e_press, e_rel, e_rep};
    endfunction

    task automatic model_reset();
        raw_dly[0] = 4'hF;
        raw_dly[1] = 4'hF;
        for (int c = 0; c < 4; c++) begin
            m_level[c] = 1'b0;
            m_run[c]   = 0;
            m_since[c] = 0;
        end
        e_gpio = '0; e_press = '0; e_rel = '0; e_rep = '0;
    endtask

    // One rising edge: the qualifier sees the pin value from two edges earlier.
    task automatic model_step(input logic [3:0] r);
        logic [3:0] x;
        bit was_held;
        x = ~raw_dly[1];
        raw_dly[1] = raw_dly[0];
        raw_dly[0] = r;
        e_press = '0; e_rel = '0; e_rep = '0;
        for (int c = 0; c < 4; c++) begin
            was_held = m_level[c] && (m_run[c] == 0);
            if (x[c] != m_level[c]) begin
                m_run[c]++;
                if (m_run[c] == D) begin
                    m_level[c] = x[c];
                    m_run[c]   = 0;
                    e_press[c] = x[c];
                    e_rel[c]   = !x[c];
                end
            end else begin
                m_run[c] = 0;
            end
            if (e_press[c]) m_since[c] = 0;
            else            m_since[c]++;
            if (RD > 0 && was_held && m_level[c] && m_run[c] == 0 &&
                m_since[c] >= RD && ((m_since[c] - RD) % RP) == 0)
                e_rep[c] = 1'b1;
            e_gpio[c] = m_level[c];
        end
    endtask

    task automatic tick(input logic [3:0] r);
        btn_raw = r;
        @(posedge clk_clk);
        model_step(r);
        #1;
    endtask

    task automatic test_reset();
        reset_reset = 1'b1;
        btn_raw = 4'hF;
        repeat (3) @(posedge clk_clk);
        #1;
        n_tests++;
        if (outs() !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0000", outs());
        end
        reset_reset = 1'b0;
        model_reset();
    endtask

    task automatic test_press_release();
        int press_at = -1;
        int rel_at = -1;
        for (int e = 1; e <= 12; e++) begin
            tick(4'hE);
            n_tests++;
            if (outs() !== exps()) begin
                n_fail++;
                $display("FAIL press_model e=%0d: got %h expected %h", e, outs(), exps());
            end
            if (press_pulse != 4'b0000 && press_at < 0) begin
                press_at = e;
                n_tests++;
                if ({gpio_export, press_pulse} !== 8'h11) begin
                    n_fail++;
                    $display("FAIL press_ch0_bits: got %h expected 11", {gpio_export, press_pulse});
                end
            end
        end
        n_tests++;
        if (press_at !== D + 2) begin
            n_fail++;
            $display("FAIL press_latency: got %0d expected %0d", press_at, D + 2);
        end
        for (int e = 1; e <= 12; e++) begin
            tick(4'hF);
            n_tests++;
            if (outs() !== exps()) begin
                n_fail++;
                $display("FAIL release_model e=%0d: got %h expected %h", e, outs(), exps());
            end
            if (release_pulse != 4'b0000 && rel_at < 0) rel_at = e;
        end
        n_tests++;
        if (rel_at !== D + 2) begin
            n_fail++;
            $display("FAIL release_latency: got %0d expected %0d", rel_at, D + 2);
        end
    endtask

    task automatic test_glitch();
        logic seen = 1'b0;
        for (int e = 1; e <= 15; e++) begin
            tick((e <= 3) ? 4'b1101 : 4'b1111);
            n_tests++;
            if (outs() !== exps()) begin
                n_fail++;
                $display("FAIL glitch_model e=%0d: got %h expected %h", e, outs(), exps());
            end
            seen |= gpio_export[1] | press_pulse[1] | release_pulse[1] | repeat_pulse[1];
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_rejected: got %b expected 0", seen);
        end
    endtask

    task automatic test_repeat_bounce();
        int p = -1;
        int got[$];
        int want[$];
        logic dropped = 1'b0;
        logic released = 1'b0;
        for (int e = 1; e <= 12 && p < 0; e++) begin
            tick(4'b1011);
            n_tests++;
            if (outs() !== exps()) begin
                n_fail++;
                $display("FAIL rep_press_model e=%0d: got %h expected %h", e, outs(), exps());
            end
            if (press_pulse[2]) p = e;
        end
        n_tests++;
        if (p !== D + 2) begin
            n_fail++;
            $display("FAIL rep_press_latency: got %0d expected %0d", p, D + 2);
        end
        // Pin bounces high at hold cycles 20 and 21; the qualifier sees it at 22..23.
        for (int k = 1; k <= 40; k++) begin
            tick((k == 20 || k == 21) ? 4'b1111 : 4'b1011);
            n_tests++;
            if (outs() !== exps()) begin
                n_fail++;
                $display("FAIL rep_hold_model k=%0d: got %h expected %h", k, outs(), exps());
            end
            if (repeat_pulse[2]) got.push_back(k);
            dropped  |= ~gpio_export[2];
            released |= release_pulse[2];
            if (k >= RD && ((k - RD) % RP) == 0 && !(k >= 22 && k <= 24)) want.push_back(k);
        end
        n_tests++;
        if (dropped !== 1'b0 || released !== 1'b0) begin
            n_fail++;
            $display("FAIL rep_bounce_hold: got drop=%b rel=%b expected drop=0 rel=0", dropped, released);
        end
        n_tests++;
        if (got.size() != want.size()) begin
            n_fail++;
            $display("FAIL rep_count: got %0d expected %0d", got.size(), want.size());
        end else begin
            for (int i = 0; i < got.size(); i++) begin
                n_tests++;
                if (got[i] != want[i]) begin
                    n_fail++;
                    $display("FAIL rep_time[%0d]: got %0d expected %0d", i, got[i], want[i]);
                end
            end
        end
        for (int e = 1; e <= 12; e++) begin
            tick(4'hF);
            n_tests++;
            if (outs() !== exps()) begin
                n_fail++;
                $display("FAIL rep_release_model e=%0d: got %h expected %h", e, outs(), exps());
            end
        end
    endtask

    task automatic test_all_channels();
        int at = -1;
        logic [3:0] val = '0;
        for (int e = 1; e <= 12; e++) begin
            tick(4'h0);
            n_tests++;
            if (outs() !== exps()) begin
                n_fail++;
                $display("FAIL all_press_model e=%0d: got %h expected %h", e, outs(), exps());
            end
            if (press_pulse != 4'b0000 && at < 0) begin at = e; val = press_pulse; end
        end
        n_tests++;
        if (at !== D + 2 || val !== 4'hF) begin
            n_fail++;
            $display("FAIL all_press: got edge %0d value %h expected edge %0d value f", at, val, D + 2);
        end
        at = -1; val = '0;
        for (int e = 1; e <= 12; e++) begin
            tick(4'hF);
            n_tests++;
            if (outs() !== exps()) begin
                n_fail++;
                $display("FAIL all_release_model e=%0d: got %h expected %h", e, outs(), exps());
            end
            if (release_pulse != 4'b0000 && at < 0) begin at = e; val = release_pulse; end
        end
        n_tests++;
        if (at !== D + 2 || val !== 4'hF) begin
            n_fail++;
            $display("FAIL all_release: got edge %0d value %h expected edge %0d value f", at, val, D + 2);
        end
    endtask

    task automatic test_reset_mid();
        int at = -1;
        logic [3:0] val = '0;
        for (int e = 1; e <= 10; e++) tick(4'b1110);
        n_tests++;
        if (gpio_export !== 4'b0001) begin
            n_fail++;
            $display("FAIL mid_pre_hold: got %b expected 0001", gpio_export);
        end
        // Channel 3 enters debounce at edge 3; reset lands three cycles into it.
        for (int e = 1; e <= 5; e++) tick(4'b0110);
        reset_reset = 1'b1;
        #1;
        n_tests++;
        if (outs() !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_reset_immediate: got %h expected 0000", outs());
        end
        model_reset();
        repeat (2) @(posedge clk_clk);
        #1;
        n_tests++;
        if (outs() !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_reset_held: got %h expected 0000", outs());
        end
        reset_reset = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick(4'b0110);
            n_tests++;
            if (outs() !== exps()) begin
                n_fail++;
                $display("FAIL mid_after_model e=%0d: got %h expected %h", e, outs(), exps());
            end
            if (press_pulse != 4'b0000 && at < 0) begin at = e; val = press_pulse; end
        end
        n_tests++;
        if (at !== D + 2 || val !== 4'b1001) begin
            n_fail++;
            $display("FAIL mid_repress: got edge %0d value %b expected edge %0d value 1001", at, val, D + 2);
        end
        for (int e = 1; e <= 12; e++) tick(4'hF);
    endtask

    task automatic test_random();
        logic [3:0] cur = 4'hF;
        int rem [4];
        for (int c = 0; c < 4; c++) rem[c] = $urandom_range(1, 20);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < 4; c++) begin
                rem[c]--;
                if (rem[c] <= 0) begin
                    cur[c] = ~cur[c];
                    rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 40) : $urandom_range(1, 6);
                end
            end
            tick(cur);
            n_tests++;
            if (outs() !== exps()) begin
                n_fail++;
                $display("FAIL random_model cyc=%0d: got %h expected %h", cyc, outs(), exps());
            end
            n_tests++;
            if ((repeat_pulse & (press_pulse | release_pulse)) !== 4'b0000) begin
                n_fail++;
                $display("FAIL random_exclusive cyc=%0d: got %b expected 0000",
                         cyc, repeat_pulse & (press_pulse | release_pulse));
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_press_release();
        test_glitch();
        test_repeat_bounce();
        test_all_channels();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
